// File: rtl/sprite_attr_fetch_pkg.sv
// Shared types and constants for the per-scanline sprite attribute scanner.
// The optional Z-depth skip is controlled by the SPRITE_ZDEPTH_SKIP_EN macro in sprite_attr_fetch.sv.
package sprite_attr_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR0 = 3'd1,
        ST_ADDR1 = 3'd2,
        ST_CHECK = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } fetch_state_e;

    // Word 0 field positions
    localparam int W0_ADDR_LSB   = 0;
    localparam int W0_MODE_BIT   = 15;
    localparam int W0_X_LSB      = 16;
    // Word 1 field positions
    localparam int W1_Y_LSB      = 0;
    localparam int W1_HFLIP_BIT  = 16;
    localparam int W1_VFLIP_BIT  = 17;
    localparam int W1_Z_LSB      = 18;
    localparam int W1_COLL_LSB   = 20;
    localparam int W1_PAL_LSB    = 24;
    localparam int W1_WIDTH_LSB  = 28;
    localparam int W1_HEIGHT_LSB = 30;

    typedef struct packed {
        logic [6:0]  idx;
        logic [11:0] addr;
        logic        mode;
        logic [9:0]  x;
        logic [5:0]  row;
        logic [1:0]  width;
        logic        hflip;
        logic [1:0]  z;
        logic [3:0]  coll;
        logic [3:0]  pal;
    } sprite_attr_t;

    function automatic logic [6:0] height_decode(input logic [1:0] code);
        return 7'd8 << code;
    endfunction

    // Index of the bottom row of a sprite, used when mirroring vertically.
    function automatic logic [5:0] height_last_row(input logic [1:0] code);
        logic [6:0] h;
        h = height_decode(code) - 7'd1;
        return h[5:0];
    endfunction

endpackage

// File: rtl/sprite_y_match.sv
// Combinational Y-range test of one sprite against a line; shared with the collision logic.
module sprite_y_match
    import sprite_attr_fetch_pkg::*;
(
    input  logic [9:0] line_i,
    input  logic [9:0] y_i,
    input  logic [1:0] height_i,
    input  logic       vflip_i,
    output logic       hit_o,
    output logic [5:0] row_o
);

    logic [9:0] delta;

    // Wrapping subtract lets sprites with Y near 1023 continue onto lines 0 and up.
    assign delta = line_i - y_i;
    assign hit_o = delta < {3'b000, height_decode(height_i)};
    assign row_o = vflip_i ? (height_last_row(height_i) - delta[5:0]) : delta[5:0];

endmodule

// File: rtl/sprite_attr_fetch.sv
// Scans all sprite entries each line and streams the intersecting ones to the renderer.
// Define SPRITE_ZDEPTH_SKIP_EN to treat Z = 0 sprites as misses.
module sprite_attr_fetch
    import sprite_attr_fetch_pkg::*;
#(
    parameter int NUM_SPRITES = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        line_start_i,
    input  logic [9:0]  line_idx_i,
    output logic        rd_en_o,
    output logic [7:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        spr_valid_o,
    input  logic        spr_ready_i,
    output logic [6:0]  spr_idx_o,
    output logic [11:0] spr_addr_o,
    output logic        spr_mode_o,
    output logic [9:0]  spr_x_o,
    output logic [5:0]  spr_row_o,
    output logic [1:0]  spr_width_o,
    output logic        spr_hflip_o,
    output logic [1:0]  spr_z_o,
    output logic [3:0]  spr_coll_o,
    output logic [3:0]  spr_pal_o,
    output logic        line_done_o,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a record is transferred on every rising edge where spr_valid_o and
    // spr_ready_i are both high; while valid is high and ready low, the record is held.

    localparam logic [6:0] LAST_IDX = 7'(NUM_SPRITES - 1);

    fetch_state_e state_q, state_d;
    logic [6:0]   n_q, n_d;
    logic [9:0]   line_q, line_d;
    logic [31:0]  w0_q, w0_d;
    sprite_attr_t rec_q, rec_d;

    logic       y_hit;
    logic       hit;
    logic [5:0] row;
    logic       unused_w0;

    assign unused_w0 = ^{w0_q[31:26], w0_q[14:12]};

    sprite_y_match u_y_match (
        .line_i   (line_q),
        .y_i      (rd_data_i[W1_Y_LSB +: 10]),
        .height_i (rd_data_i[W1_HEIGHT_LSB +: 2]),
        .vflip_i  (rd_data_i[W1_VFLIP_BIT]),
        .hit_o    (y_hit),
        .row_o    (row)
    );

`ifdef SPRITE_ZDEPTH_SKIP_EN
    assign hit = y_hit && (rd_data_i[W1_Z_LSB +: 2] != 2'd0);
`else
    assign hit = y_hit;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            n_q     <= 7'd0;
            line_q  <= 10'd0;
            w0_q    <= 32'd0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            line_q  <= line_d;
            w0_q    <= w0_d;
            rec_q   <= rec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        line_d  = line_q;
        w0_d    = w0_q;
        rec_d   = rec_q;

        case (state_q)
            ST_IDLE: ;
            ST_ADDR0: state_d = ST_ADDR1;
            ST_ADDR1: begin
                w0_d    = rd_data_i;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                rec_d.idx   = n_q;
                rec_d.addr  = w0_q[W0_ADDR_LSB +: 12];
                rec_d.mode  = w0_q[W0_MODE_BIT];
                rec_d.x     = w0_q[W0_X_LSB +: 10];
                rec_d.row   = row;
                rec_d.width = rd_data_i[W1_WIDTH_LSB +: 2];
                rec_d.hflip = rd_data_i[W1_HFLIP_BIT];
                rec_d.z     = rd_data_i[W1_Z_LSB +: 2];
                rec_d.coll  = rd_data_i[W1_COLL_LSB +: 4];
                rec_d.pal   = rd_data_i[W1_PAL_LSB +: 4];
                if (hit) begin
                    state_d = ST_EMIT;
                end else if (n_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = n_q + 7'd1;
                    state_d = ST_ADDR0;
                end
            end
            ST_EMIT: begin
                if (spr_ready_i) begin
                    if (n_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        n_d     = n_q + 7'd1;
                        state_d = ST_ADDR0;
                    end
                end
            end
            ST_DONE: begin
                n_d     = 7'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new line always wins, aborting whatever scan is in flight.
        if (line_start_i) begin
            state_d = ST_ADDR0;
            n_d     = 7'd0;
            line_d  = line_idx_i;
        end
    end

    assign rd_en_o     = (state_q == ST_ADDR0) || (state_q == ST_ADDR1);
    assign rd_addr_o   = (state_q == ST_ADDR0) ? {n_q, 1'b0} :
                         (state_q == ST_ADDR1) ? {n_q, 1'b1} : 8'd0;
    assign spr_valid_o = (state_q == ST_EMIT);
    assign line_done_o = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

    assign spr_idx_o   = rec_q.idx;
    assign spr_addr_o  = rec_q.addr;
    assign spr_mode_o  = rec_q.mode;
    assign spr_x_o     = rec_q.x;
    assign spr_row_o   = rec_q.row;
    assign spr_width_o = rec_q.width;
    assign spr_hflip_o = rec_q.hflip;
    assign spr_z_o     = rec_q.z;
    assign spr_coll_o  = rec_q.coll;
    assign spr_pal_o   = rec_q.pal;

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Scoreboard bench for sprite_attr_fetch: directed lines against a small attribute RAM model.
module tb_sprite_attr_fetch;
  import sprite_attr_fetch_pkg::*;

  localparam int RW = 49;

  logic        clk_i;
  logic        rst_i;
  logic        line_start_i;
  logic [9:0]  line_idx_i;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic        spr_valid_o;
  logic        spr_ready_i;
  logic [6:0]  spr_idx_o;
  logic [11:0] spr_addr_o;
  logic        spr_mode_o;
  logic [9:0]  spr_x_o;
  logic [5:0]  spr_row_o;
  logic [1:0]  spr_width_o;
  logic        spr_hflip_o;
  logic [1:0]  spr_z_o;
  logic [3:0]  spr_coll_o;
  logic [3:0]  spr_pal_o;
  logic        line_done_o;
  logic [2:0]  dbg_state_o;

  sprite_attr_fetch dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .line_start_i (line_start_i),
    .line_idx_i   (line_idx_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .spr_valid_o  (spr_valid_o),
    .spr_ready_i  (spr_ready_i),
    .spr_idx_o    (spr_idx_o),
    .spr_addr_o   (spr_addr_o),
    .spr_mode_o   (spr_mode_o),
    .spr_x_o      (spr_x_o),
    .spr_row_o    (spr_row_o),
    .spr_width_o  (spr_width_o),
    .spr_hflip_o  (spr_hflip_o),
    .spr_z_o      (spr_z_o),
    .spr_coll_o   (spr_coll_o),
    .spr_pal_o    (spr_pal_o),
    .line_done_o  (line_done_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- attribute RAM model ----------------
  logic [31:0] mem [256];
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
  end

  logic [11:0] t_addr [128];
  logic        t_mode [128];
  logic [9:0]  t_x    [128];
  logic [1:0]  t_w    [128];
  logic        t_hf   [128];
  logic [1:0]  t_z    [128];
  logic [3:0]  t_c    [128];
  logic [3:0]  t_p    [128];

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic          hold_pend = 1'b0;
  logic [RW-1:0] hold_rec;
  logic [RW-1:0] cur;
  logic [RW-1:0] exp_rec;

  function automatic logic [RW-1:0] pack_rec(input logic [6:0] idx, input logic [11:0] a,
      input logic m, input logic [9:0] x, input logic [5:0] row, input logic [1:0] w,
      input logic hf, input logic [1:0] z, input logic [3:0] c, input logic [3:0] p);
    return {idx, a, m, x, row, w, hf, z, c, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_spr(input int n, input logic [11:0] a, input logic m, input logic [9:0] x,
      input logic [9:0] y, input logic hf, input logic vf, input logic [1:0] z,
      input logic [3:0] c, input logic [3:0] p, input logic [1:0] w, input logic [1:0] h);
    t_addr[n] = a; t_mode[n] = m; t_x[n] = x; t_w[n] = w;
    t_hf[n] = hf; t_z[n] = z; t_c[n] = c; t_p[n] = p;
    mem[2*n]   = {6'd0, x, m, 3'd0, a};
    mem[2*n+1] = {h, w, p, c, z, vf, hf, 6'd0, y};
  endtask

  // Parks a sprite on lines 500..507, which no test scans.
  task automatic park_spr(input int n);
    set_spr(n, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
            10'd500, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'd0);
  endtask

  task automatic expect_spr(input int n, input logic [5:0] row);
    exp_q.push_back(pack_rec(7'(n), t_addr[n], t_mode[n], t_x[n], row, t_w[n],
                             t_hf[n], t_z[n], t_c[n], t_p[n]));
  endtask

  task automatic pulse_line(input logic [9:0] l);
    line_idx_i   = l;
    line_start_i = 1'b1;
    @(posedge clk_i); #1;
    line_start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (done_cnt == start) check({name, "_done_timeout"}, 64'd0, 64'd1);
    repeat (2) @(posedge clk_i);
    #1;
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!spr_valid_o && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({name, "_valid_seen"}, 64'(spr_valid_o), 64'd1);
  endtask

  task automatic scan(input string name, input logic [9:0] l);
    pulse_line(l);
    wait_done(name, 1200);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 64'(spr_valid_o), 64'd0);
    check({name, "_rd_en"}, 64'(rd_en_o), 64'd0);
    check({name, "_rd_addr"}, 64'(rd_addr_o), 64'd0);
    check({name, "_done"}, 64'(line_done_o), 64'd0);
    check({name, "_record"}, 64'(pack_rec(spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_row_o,
          spr_width_o, spr_hflip_o, spr_z_o, spr_coll_o, spr_pal_o)), 64'd0);
    check({name, "_state"}, 64'(dbg_state_o), 64'(ST_IDLE));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_pend = 1'b0;
    end else begin
      cur = pack_rec(spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_row_o, spr_width_o,
                     spr_hflip_o, spr_z_o, spr_coll_o, spr_pal_o);
      if (spr_valid_o && hold_pend) check("record_hold", 64'(cur), 64'(hold_rec));
      if (spr_valid_o && spr_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 64'(cur), 64'd0 - 64'd1);
        end else begin
          exp_rec = exp_q.pop_front();
          check("record", 64'(cur), 64'(exp_rec));
        end
      end
      hold_pend = spr_valid_o && !spr_ready_i;
      hold_rec  = cur;
      if (line_done_o) done_cnt++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int d0;
    rst_i = 1'b1;
    line_start_i = 1'b0;
    line_idx_i = 10'd0;
    spr_ready_i = 1'b1;
    for (int n = 0; n < 128; n++) park_spr(n);
    repeat (3) @(posedge clk_i);
    #1;
    check_idle_outputs("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Full-miss scan: done lands exactly 385 cycles after the start pulse.
    line_idx_i = 10'd20;
    line_start_i = 1'b1;
    @(posedge clk_i); #1;
    line_start_i = 1'b0;
    cyc = 1;
    while (!line_done_o && cyc < 1000) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("miss_scan_latency", 64'(cyc), 64'd385);
    repeat (3) @(posedge clk_i);
    #1;

    // Y=100, height 16, no vflip; line 107 -> row 7.
    set_spr(0, 12'h123, 1'b1, 10'd200, 10'd100, 1'b0, 1'b0, 2'd2, 4'h5, 4'h9, 2'd2, 2'd1);
    expect_spr(0, 6'd7);
    scan("y100_l107", 10'd107);

    // Same sprite mirrored: line 100 -> row 15; line 116 is one past the bottom.
    set_spr(0, 12'h123, 1'b1, 10'd200, 10'd100, 1'b1, 1'b1, 2'd2, 4'h5, 4'h9, 2'd2, 2'd1);
    expect_spr(0, 6'd15);
    scan("vflip_l100", 10'd100);
    scan("vflip_l116", 10'd116);

    // Y=1020, height 8 wraps: line 3 -> row 7, line 4 misses.
    set_spr(0, 12'hABC, 1'b0, 10'd1023, 10'd1020, 1'b0, 1'b0, 2'd3, 4'hA, 4'h3, 2'd1, 2'd0);
    expect_spr(0, 6'd7);
    scan("wrap_l3", 10'd3);
    scan("wrap_l4", 10'd4);
    park_spr(0);

    // Sprites 5 and 9 on line 310 with a 10-cycle renderer stall.
    set_spr(5, 12'h055, 1'b1, 10'd17, 10'd300, 1'b1, 1'b0, 2'd1, 4'h1, 4'h2, 2'd3, 2'd2);
    set_spr(9, 12'h099, 1'b0, 10'd640, 10'd305, 1'b0, 1'b1, 2'd3, 4'hF, 4'hE, 2'd0, 2'd0);
    spr_ready_i = 1'b0;
    expect_spr(5, 6'd10);
    expect_spr(9, 6'd2);
    pulse_line(10'd310);
    wait_valid("stall", 200);
    repeat (10) @(posedge clk_i);
    #1;
    check("stall_valid", 64'(spr_valid_o), 64'd1);
    check("stall_idx", 64'(spr_idx_o), 64'd5);
    spr_ready_i = 1'b1;
    wait_done("stall", 1200);

    // New line mid-EMIT aborts the scan and restarts at entry 0.
    spr_ready_i = 1'b0;
    d0 = done_cnt;
    pulse_line(10'd310);
    wait_valid("abort", 200);
    line_idx_i = 10'd310;
    line_start_i = 1'b1;
    @(posedge clk_i); #1;
    line_start_i = 1'b0;
    check("abort_valid_drop", 64'(spr_valid_o), 64'd0);
    check("abort_rd_en", 64'(rd_en_o), 64'd1);
    check("abort_rd_addr", 64'(rd_addr_o), 64'd0);
    expect_spr(5, 6'd10);
    expect_spr(9, 6'd2);
    spr_ready_i = 1'b1;
    wait_done("abort", 1200);
    repeat (20) @(posedge clk_i);
    #1;
    check("abort_done_count", 64'(done_cnt - d0), 64'd1);
    park_spr(5);
    park_spr(9);

    // Z = 0 sprite hitting line 602.
    set_spr(3, 12'h333, 1'b0, 10'd33, 10'd600, 1'b0, 1'b0, 2'd0, 4'h3, 4'h3, 2'd0, 2'd0);
`ifndef SPRITE_ZDEPTH_SKIP_EN
    expect_spr(3, 6'd2);
`endif
    scan("zero_z", 10'd602);
    park_spr(3);

    // Reset in the middle of a scan.
    d0 = done_cnt;
    pulse_line(10'd20);
    repeat (50) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_idle_outputs("mid_reset");
    rst_i = 1'b0;
    repeat (420) @(posedge clk_i);
    #1;
    check("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_reset_still_idle", 64'(dbg_state_o), 64'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
